periph_bridge: RTL

Bridges the core's memory-mapped data port to the peripheral bus consumed by the machine timer and other register-mapped peripherals. Posts writes into a small in-order FIFO so stores retire without stalling. Performs reads only after all older writes have drained, and times out reads that never receive a response. Sits directly upstream of the timer: its peripheral-side ports connect one-to-one to the timer's write and read ports.

---
 rtl/periph_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/periph_bridge.sv
// ============================================================================
// periph_bridge : posted-write FIFO and ordered, time-limited reads to the peripheral bus
// Revision 1.0
// ============================================================================
`default_nettype none

module periph_bridge #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   // core side
   input  logic        cpu_wvalid,
   output logic        cpu_wready,
   input  logic [31:0] cpu_waddr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_wstrb,
   input  logic        cpu_rvalid,
   output logic        cpu_rready,
   input  logic [31:0] cpu_raddr,
   output logic        cpu_rresp,
   output logic [31:0] cpu_rdata,
   output logic        cpu_rerr,
   // peripheral side
   output logic        per_wready,
   input  logic        per_wvalid,
   output logic [31:0] per_waddr,
   output logic [31:0] per_wdata,
   output logic [3:0]  per_wstrb,
   output logic        per_rready,
   input  logic        per_rvalid,
   output logic [31:0] per_raddr,
   input  logic        per_rresp,
   input  logic [31:0] per_rdata
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAIN = 3'd1,
      RREQ  = 3'd2,
      RWAIT = 3'd3,
      RDONE = 3'd4
   } state_t;

   state_t      state;
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic [7:0]  wait_cnt;

   logic [31:0] addr_mem [DEPTH];
   logic [31:0] data_mem [DEPTH];
   logic [3:0]  strb_mem [DEPTH];

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic rd_accept;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   // Handshakes are held low while reset is asserted, not merely after the first edge.
   assign cpu_wready = !reset && !full && (state == IDLE);
   assign cpu_rready = !reset && (state == IDLE);

   assign push      = cpu_wvalid && cpu_wready;
   assign pop       = per_wready && per_wvalid;
   assign rd_accept = cpu_rvalid && cpu_rready;

   assign per_wready = !empty;
   assign per_waddr  = addr_mem[rptr[AW-1:0]];
   assign per_wdata  = data_mem[rptr[AW-1:0]];
   assign per_wstrb  = strb_mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wptr[AW-1:0]] <= cpu_waddr;
         data_mem[wptr[AW-1:0]] <= cpu_wdata;
         strb_mem[wptr[AW-1:0]] <= cpu_wstrb;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         per_rready <= 1'b0;
         per_raddr  <= '0;
         cpu_rresp  <= 1'b0;
         cpu_rdata  <= '0;
         cpu_rerr   <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cpu_rresp <= 1'b0;
               if (rd_accept) begin
                  per_raddr <= cpu_raddr;
                  // A write accepted alongside the read is older, so it must drain first.
                  if (empty && !push) begin
                     state      <= RREQ;
                     per_rready <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (empty) begin
                  state      <= RREQ;
                  per_rready <= 1'b1;
               end
            end
            RREQ: begin
               if (per_rvalid) begin
                  state      <= RWAIT;
                  per_rready <= 1'b0;
                  wait_cnt   <= '0;
               end
            end
            RWAIT: begin
               // wait_cnt counts idle RWAIT cycles; the read is abandoned once
               // TIMEOUT of them have elapsed without a response.
               if (per_rresp) begin
                  cpu_rdata <= per_rdata;
                  cpu_rerr  <= 1'b0;
                  cpu_rresp <= 1'b1;
                  state     <= RDONE;
               end else if (wait_cnt == TO_LIMIT) begin
                  cpu_rdata <= '0;
                  cpu_rerr  <= 1'b1;
                  cpu_rresp <= 1'b1;
                  state     <= RDONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RDONE: begin
               cpu_rresp <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state      <= IDLE;
               per_rready <= 1'b0;
               cpu_rresp  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
